// File: rtl/bitonic_pkg.sv
// bitonic_pkg: stage geometry helpers and skid-buffer state encoding shared by the
// pipelined bitonic merger.
package bitonic_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_TWO
  } skid_state_e;

  function automatic int unsigned num_stages(input int unsigned log_p);
    return log_p + 1;
  endfunction

  // Partner distance of stage s; stage 0 instead pairs k with 2P-1-k.
  function automatic int unsigned stage_span(input int unsigned s, input int unsigned log_p);
    return (32'd1 << log_p) >> s;
  endfunction

  function automatic int unsigned pair_lo(input int unsigned s, input int unsigned j,
                                          input int unsigned log_p);
    int unsigned span;
    span = stage_span(s, log_p);
    return (j / span) * 2 * span + (j % span);
  endfunction

  function automatic int unsigned pair_hi(input int unsigned s, input int unsigned j,
                                          input int unsigned log_p);
    if (s == 0) return 2 * (32'd1 << log_p) - 1 - j;
    return pair_lo(s, j, log_p) + stage_span(s, log_p);
  endfunction

endpackage

// File: rtl/bitonic_merge_pipe_cas.sv
// bitonic_cas: registered compare-and-swap cell; ties keep the original order.
module bitonic_cas #(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_min,
  output logic [DATA_WIDTH-1:0] o_max
);

  logic [DATA_WIDTH-1:0] min_d, min_q;
  logic [DATA_WIDTH-1:0] max_d, max_q;

  always_comb begin
    min_d = i_a;
    max_d = i_b;
    if (i_a > i_b) begin
      min_d = i_b;
      max_d = i_a;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign o_min = min_q;
  assign o_max = max_q;

endmodule

// File: rtl/bitonic_merge_pipe.sv
// bitonic_merge_pipe: pipelined merge of two ascending P-tuples into a sorted 2P result.
// Define BITONIC_MERGE_SKID_EN to add a 2-entry output skid buffer with registered o_ready.
module bitonic_merge_pipe
  import bitonic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned LOG_P      = 4,
  parameter int unsigned SB_WIDTH   = 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [(1<<LOG_P)*DATA_WIDTH-1:0]   i_elems_0,
  input  logic [(1<<LOG_P)*DATA_WIDTH-1:0]   i_elems_1,
  input  logic [SB_WIDTH-1:0]                i_switch_output,
  input  logic [(1<<LOG_P)*DATA_WIDTH-1:0]   i_top_tuple,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [(1<<LOG_P)*DATA_WIDTH-1:0]   o_elems_0,
  output logic [(1<<LOG_P)*DATA_WIDTH-1:0]   o_elems_1,
  output logic [SB_WIDTH-1:0]                o_switch_output,
  output logic [(1<<LOG_P)*DATA_WIDTH-1:0]   o_top_tuple,
  output logic [LOG_P+2:0]                   o_inflight
);

  localparam int unsigned P   = 1 << LOG_P;
  localparam int unsigned S   = num_stages(LOG_P);
  localparam int unsigned IFW = LOG_P + 3;
  localparam int unsigned TW  = 2 * P * DATA_WIDTH;

  typedef struct packed {
    logic [SB_WIDTH-1:0]     sw;
    logic [P*DATA_WIDTH-1:0] top;
  } sb_t;

  logic                  pipe_en;
  logic                  accept;
  logic                  consume;
  logic [DATA_WIDTH-1:0] elem [S+1][2*P];
  logic [TW-1:0]         pipe_out;
  logic [S-1:0]          v_q, v_d;
  sb_t                   sb_q [S];
  sb_t                   sb_d [S];
  logic [IFW-1:0]        inflight_q, inflight_d;

  for (genvar k = 0; k < P; k = k + 1) begin : g_in
    assign elem[0][k]     = i_elems_0[k*DATA_WIDTH +: DATA_WIDTH];
    assign elem[0][k + P] = i_elems_1[k*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar s = 0; s < S; s = s + 1) begin : g_stage
    for (genvar j = 0; j < P; j = j + 1) begin : g_cas
      localparam int unsigned LO = pair_lo(s, j, LOG_P);
      localparam int unsigned HI = pair_hi(s, j, LOG_P);
      bitonic_cas #(.DATA_WIDTH(DATA_WIDTH)) u_cas (
        .i_clk (i_clk),
        .i_en  (pipe_en),
        .i_a   (elem[s][LO]),
        .i_b   (elem[s][HI]),
        .o_min (elem[s+1][LO]),
        .o_max (elem[s+1][HI])
      );
    end
  end

  always_comb begin
    pipe_out = '0;
    for (int unsigned k = 0; k < 2 * P; k++) begin
      pipe_out[k*DATA_WIDTH +: DATA_WIDTH] = elem[S][k];
    end
  end

  assign accept  = i_valid & o_ready;
  assign consume = o_valid & i_ready;

  // Bubbles travel with the ranks; all ranks shift together on pipe_en.
  always_comb begin
    v_d  = v_q;
    sb_d = sb_q;
    if (pipe_en) begin
      v_d     = {v_q[S-2:0], accept};
      sb_d[0] = {i_switch_output, i_top_tuple};
      for (int unsigned s = 1; s < S; s++) begin
        sb_d[s] = sb_q[s-1];
      end
    end
  end

  assign inflight_d = inflight_q + IFW'(accept) - IFW'(consume);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_q        <= '0;
      inflight_q <= '0;
      for (int unsigned s = 0; s < S; s++) begin
        sb_q[s].sw <= '0;
      end
    end else begin
      v_q        <= v_d;
      sb_q       <= sb_d;
      inflight_q <= inflight_d;
    end
  end

  assign o_inflight = inflight_q;

`ifdef BITONIC_MERGE_SKID_EN
  skid_state_e   state_q, state_d;
  logic [TW-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  sb_t           head_sb_q, head_sb_d, tail_sb_q, tail_sb_d;
  logic          push, pop;

  assign pipe_en = (state_q != SKID_TWO);
  assign push    = v_q[S-1] & pipe_en;
  assign pop     = (state_q != SKID_EMPTY) & i_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sb_d   = head_sb_q;
    tail_data_d = tail_data_q;
    tail_sb_d   = tail_sb_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          state_d     = SKID_ONE;
          head_data_d = pipe_out;
          head_sb_d   = sb_q[S-1];
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          head_data_d = pipe_out;
          head_sb_d   = sb_q[S-1];
        end else if (push) begin
          state_d     = SKID_TWO;
          tail_data_d = pipe_out;
          tail_sb_d   = sb_q[S-1];
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (pop) begin
          state_d     = SKID_ONE;
          head_data_d = tail_data_q;
          head_sb_d   = tail_sb_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= SKID_EMPTY;
      head_sb_q.sw <= '0;
      tail_sb_q.sw <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_sb_q   <= head_sb_d;
      tail_data_q <= tail_data_d;
      tail_sb_q   <= tail_sb_d;
    end
  end

  assign o_ready         = pipe_en & ~i_rst;
  assign o_valid         = (state_q != SKID_EMPTY);
  assign o_elems_0       = head_data_q[P*DATA_WIDTH-1:0];
  assign o_elems_1       = head_data_q[TW-1:P*DATA_WIDTH];
  assign o_switch_output = head_sb_q.sw;
  assign o_top_tuple     = head_sb_q.top;
`else
  assign pipe_en         = ~v_q[S-1] | i_ready;
  assign o_ready         = pipe_en & ~i_rst;
  assign o_valid         = v_q[S-1];
  assign o_elems_0       = pipe_out[P*DATA_WIDTH-1:0];
  assign o_elems_1       = pipe_out[TW-1:P*DATA_WIDTH];
  assign o_switch_output = sb_q[S-1].sw;
  assign o_top_tuple     = sb_q[S-1].top;
`endif

endmodule

// File: tb/tb_bitonic_merge_pipe.sv
// tb_bitonic_merge_pipe: directed and random checks of the bitonic merger (P=4, 8-bit
// elements) against a sort-based reference model and handshake scoreboard.
module tb_bitonic_merge_pipe;

  localparam int unsigned DW    = 8;
  localparam int unsigned LOG_P = 2;
  localparam int unsigned P     = 4;
  localparam int unsigned SBW   = 1;
  localparam int unsigned S     = LOG_P + 1;
  localparam int unsigned IFW   = LOG_P + 3;
`ifdef BITONIC_MERGE_SKID_EN
  localparam int unsigned LAT  = S + 1;
  localparam int unsigned PEAK = S + 2;
`else
  localparam int unsigned LAT  = S;
  localparam int unsigned PEAK = S;
`endif

  logic            clk = 1'b0;
  logic            rst, i_valid, o_ready, o_valid, i_ready;
  logic [P*DW-1:0] e0, e1, top, oe0, oe1, otop;
  logic [SBW-1:0]  sw, osw;
  logic [IFW-1:0]  inflight;

  always #5 clk = ~clk;

  bitonic_merge_pipe #(.DATA_WIDTH(DW), .LOG_P(LOG_P), .SB_WIDTH(SBW)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_elems_0       (e0),
    .i_elems_1       (e1),
    .i_switch_output (sw),
    .i_top_tuple     (top),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_elems_0       (oe0),
    .o_elems_1       (oe1),
    .o_switch_output (osw),
    .o_top_tuple     (otop),
    .o_inflight      (inflight)
  );

  typedef struct {
    logic [P*DW-1:0] lo;
    logic [P*DW-1:0] hi;
    logic [P*DW-1:0] top;
    logic [SBW-1:0]  sw;
  } exp_t;

  exp_t            sbq[$];
  int              checks = 0;
  int              errors = 0;
  int              model_inflight = 0;
  int              cyc = 0;
  bit              acc_hist [0:4095];
  bit              prev_stall = 0;
  logic [P*DW-1:0] held_lo, held_hi, held_top;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the merged result is simply the sorted multiset of all 2P elements.
  function automatic void ref_merge(input logic [P*DW-1:0] a, input logic [P*DW-1:0] b,
                                    output logic [P*DW-1:0] lo, output logic [P*DW-1:0] hi);
    int unsigned q[$];
    for (int k = 0; k < P; k++) begin
      q.push_back(int'(a[k*DW +: DW]));
      q.push_back(int'(b[k*DW +: DW]));
    end
    q.sort();
    lo = '0;
    hi = '0;
    for (int k = 0; k < P; k++) begin
      lo[k*DW +: DW] = DW'(q[k]);
      hi[k*DW +: DW] = DW'(q[P+k]);
    end
  endfunction

  function automatic logic [P*DW-1:0] rand_sorted();
    int unsigned     q[$];
    int unsigned     lim;
    logic [P*DW-1:0] r;
    lim = ($urandom_range(0, 1) == 0) ? 15 : 255;
    for (int k = 0; k < P; k++) q.push_back($urandom_range(0, lim));
    q.sort();
    r = '0;
    for (int k = 0; k < P; k++) r[k*DW +: DW] = DW'(q[k]);
    return r;
  endfunction

  task automatic new_data();
    e0  = rand_sorted();
    e1  = rand_sorted();
    top = $urandom;
    sw  = SBW'($urandom_range(0, 1));
  endtask

  // One clock: evaluate handshakes, check outputs, update the model, advance.
  task automatic cycle(output bit acc);
    bit              con;
    exp_t            e;
    logic [P*DW-1:0] lo, hi;
    #1;
    acc = (i_valid & o_ready) === 1'b1;
    con = (o_valid & i_ready) === 1'b1;
    if (prev_stall) begin
      chk("stall_valid", 64'(o_valid), 64'd1);
      chk("stall_lo", 64'(oe0), 64'(held_lo));
      chk("stall_hi", 64'(oe1), 64'(held_hi));
      chk("stall_top", 64'(otop), 64'(held_top));
    end
    if (con) begin
      if (sbq.size() == 0) begin
        chk("spurious_valid", 64'(o_valid), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("out_lo", 64'(oe0), 64'(e.lo));
        chk("out_hi", 64'(oe1), 64'(e.hi));
        chk("out_top", 64'(otop), 64'(e.top));
        chk("out_sw", 64'(osw), 64'(e.sw));
      end
    end
    prev_stall = (o_valid & ~i_ready) === 1'b1;
    held_lo    = oe0;
    held_hi    = oe1;
    held_top   = otop;
    if (acc) begin
      ref_merge(e0, e1, lo, hi);
      e.lo  = lo;
      e.hi  = hi;
      e.top = top;
      e.sw  = sw;
      sbq.push_back(e);
    end
    model_inflight += int'(acc) - int'(con);
    if (cyc < 4096) acc_hist[cyc] = acc;
    @(posedge clk);
    #1;
    cyc++;
    chk("inflight", 64'(inflight), 64'(model_inflight));
  endtask

  task automatic drain();
    bit a;
    int n = 0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    while (sbq.size() != 0 && n < 50) begin
      cycle(a);
      n++;
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    bit pending;
    int lat, sent, peak;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    e0 = '0; e1 = '0; top = '0; sw = '0;

    // Reset state
    @(posedge clk); #1;
    chk("ready_in_reset", 64'(o_ready), 64'd0);
    @(posedge clk); #1;
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_inflight", 64'(inflight), 64'd0);
    chk("reset_switch", 64'(osw), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 64'(o_ready), 64'd1);

    // Directed merge with side-band and latency
    e0 = {8'd9, 8'd6, 8'd4, 8'd1};
    e1 = {8'd8, 8'd7, 8'd3, 8'd2};
    top = 32'd5; sw = 1'b1; i_valid = 1'b1;
    cycle(acc);
    chk("merge_accept", 64'(acc), 64'd1);
    i_valid = 1'b0; top = '0; sw = '0;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 20) begin
      cycle(acc);
      lat++;
    end
    chk("merge_latency", 64'(lat), 64'(LAT));
    chk("merge_lo", 64'(oe0), 64'h04030201);
    chk("merge_hi", 64'(oe1), 64'h09080706);
    chk("merge_top", 64'(otop), 64'd5);
    chk("merge_sw", 64'(osw), 64'd1);
    cycle(acc);

    // Ties and extremes
    e0 = {4{8'd5}}; e1 = {4{8'd5}}; i_valid = 1'b1;
    cycle(acc);
    e0 = '0; e1 = '1;
    cycle(acc);
    drain();

    // Bubbles: o_valid follows the accept pattern LAT cycles later
    for (int i = 0; i < 12; i++) begin
      new_data();
      i_valid = (i % 2 == 0) && (i < 8);
      cycle(acc);
      chk("bubble_valid", 64'(o_valid), 64'(acc_hist[cyc-LAT]));
    end
    drain();

    // Back-pressure mid-stream
    sent = 0; peak = 0;
    new_data();
    for (int i = 0; i < 100 && (sent < 8 || sbq.size() != 0); i++) begin
      i_valid = (sent < 8);
      i_ready = !(i >= 4 && i < 9);
      cycle(acc);
      if (acc) begin
        sent++;
        new_data();
      end
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    chk("bp_sent", 64'(sent), 64'd8);
    chk("bp_drained", 64'(sbq.size()), 64'd0);
    chk("bp_peak_inflight", 64'(peak), 64'(PEAK));
    drain();

    // Reset with tuples in flight
    new_data(); i_valid = 1'b1;
    cycle(acc);
    new_data();
    cycle(acc);
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("ready_in_reset2", 64'(o_ready), 64'd0);
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    sbq.delete();
    model_inflight = 0;
    prev_stall = 1'b0;
    chk("rst_mid_valid", 64'(o_valid), 64'd0);
    chk("rst_mid_inflight", 64'(inflight), 64'd0);
    new_data(); i_valid = 1'b1;
    cycle(acc);
    i_valid = 1'b0;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 20) begin
      cycle(acc);
      lat++;
    end
    chk("rst_new_latency", 64'(lat), 64'(LAT));
    drain();

    // Random traffic with random back-pressure
    pending = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!pending) begin
        new_data();
        i_valid = ($urandom_range(0, 3) != 0);
        pending = i_valid;
      end
      i_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc) pending = 1'b0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
